// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode/funct constants, internal ALU-op codes and ALU control codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // NONE marks states that do not use the ALU; their alucont stays 000.
  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'b00,
    ALUOP_ADD   = 2'b01,
    ALUOP_SUB   = 2'b10,
    ALUOP_FUNCT = 2'b11
  } aluop_t;

  localparam logic [2:0] ALUCONT_AND  = 3'b000;
  localparam logic [2:0] ALUCONT_OR   = 3'b001;
  localparam logic [2:0] ALUCONT_ADD  = 3'b010;
  localparam logic [2:0] ALUCONT_SUB  = 3'b110;
  localparam logic [2:0] ALUCONT_SLT  = 3'b111;
  localparam logic [2:0] ALUCONT_NONE = 3'b000;

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// ALU control decoder: maps the controller's ALU-op request and the R-type
// funct field to the 3-bit ALU operation. funct_valid depends on funct only,
// so the controller can judge R-type legality while still in DECODE.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       funct_valid
);

  logic [2:0] w_funct_cont;

  // Decode the funct field into an ALU operation and flag unsupported codes.
  always_comb begin
    w_funct_cont = ALUCONT_NONE;
    funct_valid  = 1'b0;
    case (funct)
      FUNCT_ADD: begin w_funct_cont = ALUCONT_ADD; funct_valid = 1'b1; end
      FUNCT_SUB: begin w_funct_cont = ALUCONT_SUB; funct_valid = 1'b1; end
      FUNCT_AND: begin w_funct_cont = ALUCONT_AND; funct_valid = 1'b1; end
      FUNCT_OR:  begin w_funct_cont = ALUCONT_OR;  funct_valid = 1'b1; end
      FUNCT_SLT: begin w_funct_cont = ALUCONT_SLT; funct_valid = 1'b1; end
      default:   begin w_funct_cont = ALUCONT_NONE; funct_valid = 1'b0; end
    endcase
  end

  // Select the ALU operation according to the requested ALU-op class.
  always_comb begin
    alucont = ALUCONT_NONE;
    case (aluop_t'(aluop))
      ALUOP_ADD:   alucont = ALUCONT_ADD;
      ALUOP_SUB:   alucont = ALUCONT_SUB;
      ALUOP_FUNCT: alucont = w_funct_cont;
      default:     alucont = ALUCONT_NONE;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM (byte-wide instruction fetch over four cycles).
// Moore outputs decoded from the state register; pcen also sees the ALU zero
// flag during BEQEX. Asynchronous reset forces FETCH1 and masks all enables.
// Optional feature macro: MIPS_CTRL_ADDI_EN (adds ADDIEX/ADDIWR and op 0x08).
module mips_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [3:0] irwrite,
  output logic [1:0] alusrcb,
  output logic [2:0] alucont,
  output logic [1:0] pcsource,
  output logic [3:0] state,
  output logic       illegal_op
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_funct_valid;
  logic       w_op_legal;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memwrite;
  logic       w_regwrite;
  logic [3:0] w_irwrite;
  aluop_t     w_aluop;

  alu_decoder u_alu_decoder (
    .aluop       (w_aluop),
    .funct       (funct),
    .alucont     (alucont),
    .funct_valid (w_funct_valid)
  );

  // State register; reset returns to FETCH1 without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH1;
    else          r_state <= w_next_state;
  end

  // Classify the current opcode (and funct for R-type) as executable.
  always_comb begin
    w_op_legal = 1'b0;
    case (op)
      OP_LB, OP_SB, OP_BEQ, OP_J: w_op_legal = 1'b1;
      OP_RTYPE:                   w_op_legal = w_funct_valid;
`ifdef MIPS_CTRL_ADDI_EN
      OP_ADDI:                    w_op_legal = 1'b1;
`endif
      default:                    w_op_legal = 1'b0;
    endcase
  end

  // Next-state logic; unused codes (and disabled ADDI states) recover to FETCH1.
  always_comb begin
    w_next_state = S_FETCH1;
    case (r_state)
      S_FETCH1:  w_next_state = S_FETCH2;
      S_FETCH2:  w_next_state = S_FETCH3;
      S_FETCH3:  w_next_state = S_FETCH4;
      S_FETCH4:  w_next_state = S_DECODE;
      S_DECODE: begin
        if (!w_op_legal)                          w_next_state = S_FETCH1;
        else if (op == OP_LB || op == OP_SB)      w_next_state = S_MEMADR;
        else if (op == OP_RTYPE)                  w_next_state = S_RTYPEEX;
        else if (op == OP_BEQ)                    w_next_state = S_BEQEX;
        else if (op == OP_J)                      w_next_state = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
        else if (op == OP_ADDI)                   w_next_state = S_ADDIEX;
`endif
        else                                      w_next_state = S_FETCH1;
      end
      S_MEMADR:  w_next_state = (op == OP_LB) ? S_LBRD : S_SBWR;
      S_LBRD:    w_next_state = S_LBWR;
      S_RTYPEEX: w_next_state = S_RTYPEWR;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX:  w_next_state = S_ADDIWR;
`endif
      default:   w_next_state = S_FETCH1;
    endcase
  end

  // Moore output decode; write-back states keep the ALU selects because the
  // register write data is taken straight from the ALU output.
  always_comb begin
    w_irwrite  = 4'b0000;
    iord       = 1'b0;
    w_memwrite = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    w_aluop    = ALUOP_NONE;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    pcsource   = 2'b00;
    case (r_state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        w_irwrite = 4'b0001 << r_state[1:0];
        alusrcb   = 2'b01;
        w_aluop   = ALUOP_ADD;
        w_pcwrite = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        w_aluop = ALUOP_ADD;
      end
      S_MEMADR, S_LBRD: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_aluop = ALUOP_ADD;
        iord    = (r_state == S_LBRD);
      end
      S_LBWR: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_SBWR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        w_aluop    = ALUOP_ADD;
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX, S_RTYPEWR: begin
        alusrca    = 1'b1;
        w_aluop    = ALUOP_FUNCT;
        w_regwrite = (r_state == S_RTYPEWR);
        regdst     = (r_state == S_RTYPEWR);
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        w_branch = 1'b1;
        pcsource = 2'b01;
      end
      S_JEX: begin
        w_pcwrite = 1'b1;
        pcsource  = 2'b10;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX, S_ADDIWR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        w_aluop    = ALUOP_ADD;
        w_regwrite = (r_state == S_ADDIWR);
      end
`endif
      default: begin
        w_irwrite = 4'b0000;
      end
    endcase
  end

  // Enables are masked by reset so nothing writes while reset_n is low.
  assign pcen       = reset_n & (w_pcwrite | (w_branch & zero));
  assign memwrite   = reset_n & w_memwrite;
  assign regwrite   = reset_n & w_regwrite;
  assign irwrite    = w_irwrite & {4{reset_n}};
  assign illegal_op = reset_n & (r_state == S_DECODE) & ~w_op_legal;
  assign state      = r_state;

endmodule

// File: tb/tb_mips_controller.sv
// Self-checking bench for mips_controller. Each directed instruction pushes
// its expected per-cycle output vectors into a scoreboard queue; the vectors
// are popped and compared one per clock, sampled just after the falling edge.
module tb_mips_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, memwrite, regdst, memtoreg, regwrite, alusrca;
  logic [3:0] irwrite;
  logic [1:0] alusrcb;
  logic [2:0] alucont;
  logic [1:0] pcsource;
  logic [3:0] state;
  logic       illegal_op;

  int n_pass  = 0;
  int n_total = 0;

  logic [22:0] sb_q[$];
  string       tag_q[$];
  logic [22:0] obs;

  mips_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .irwrite(irwrite), .alusrcb(alusrcb), .alucont(alucont),
    .pcsource(pcsource), .state(state), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state, pcen, irwrite, iord, memwrite, regdst, memtoreg,
                regwrite, alusrca, alusrcb, alucont, pcsource, illegal_op};

  function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h20 || o == 6'h28 || o == 6'h04 || o == 6'h02) return 1'b1;
    if (o == 6'h00)
      return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A);
`ifdef MIPS_CTRL_ADDI_EN
    if (o == 6'h08) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [2:0] funct_cont(input logic [5:0] f);
    case (f)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2A: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Expected output vector for a state, built from the control table.
  function automatic logic [22:0] exp_vec(input logic [3:0] s, input logic [5:0] o,
                                          input logic [5:0] f, input logic z);
    logic p; logic [3:0] irw; logic io, mw, rd, mr, rw, sa, ill;
    logic [1:0] sb, ps; logic [2:0] ac;
    p = 0; irw = 0; io = 0; mw = 0; rd = 0; mr = 0; rw = 0; sa = 0; ill = 0;
    sb = 0; ps = 0; ac = 0;
    case (s)
      4'd0: begin irw = 4'b0001; sb = 2'b01; ac = 3'b010; p = 1; end
      4'd1: begin irw = 4'b0010; sb = 2'b01; ac = 3'b010; p = 1; end
      4'd2: begin irw = 4'b0100; sb = 2'b01; ac = 3'b010; p = 1; end
      4'd3: begin irw = 4'b1000; sb = 2'b01; ac = 3'b010; p = 1; end
      4'd4: begin sb = 2'b11; ac = 3'b010; ill = ~is_legal(o, f); end
      4'd5: begin sa = 1; sb = 2'b10; ac = 3'b010; end
      4'd6: begin sa = 1; sb = 2'b10; ac = 3'b010; io = 1; end
      4'd7: begin rw = 1; mr = 1; end
      4'd8: begin sa = 1; sb = 2'b10; ac = 3'b010; io = 1; mw = 1; end
      4'd9: begin sa = 1; ac = funct_cont(f); end
      4'd10: begin sa = 1; ac = funct_cont(f); rw = 1; rd = 1; end
      4'd11: begin sa = 1; ac = 3'b110; p = z; ps = 2'b01; end
      4'd12: begin p = 1; ps = 2'b10; end
`ifdef MIPS_CTRL_ADDI_EN
      4'd13: begin sa = 1; sb = 2'b10; ac = 3'b010; end
      4'd14: begin sa = 1; sb = 2'b10; ac = 3'b010; rw = 1; end
`endif
      default: begin p = 0; end
    endcase
    return {s, p, irw, io, mw, rd, mr, rw, sa, sb, ac, ps, ill};
  endfunction

  // While reset is low: FETCH1 selects with every enable forced off.
  function automatic logic [22:0] exp_reset();
    return {4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            2'b01, 3'b010, 2'b00, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // Drive one instruction, queue its expected trace, then compare per cycle.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input logic [31:0] seq, input int n);
    logic [22:0] e;
    string t;
    op = o; funct = f; zero = z;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(exp_vec(seq[4*i +: 4], o, f, z));
      tag_q.push_back($sformatf("%s_c%0d", name, i));
    end
    for (int i = 0; i < n; i++) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check(t, obs, e);
      @(negedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; op = 6'h00; funct = 6'h20; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("reset_hold%0d", i), obs, exp_reset());
    end
    reset_n = 1'b1; #1;

    run_instr("lb",        6'h20, 6'h00, 1'b1, 32'h76543210, 8);
    run_instr("beq_z1",    6'h04, 6'h00, 1'b1, 32'h00B43210, 6);
    run_instr("beq_z0",    6'h04, 6'h00, 1'b0, 32'h00B43210, 6);
    run_instr("rtype_slt", 6'h00, 6'h2A, 1'b1, 32'h0A943210, 7);
    run_instr("rtype_sub", 6'h00, 6'h22, 1'b0, 32'h0A943210, 7);
    run_instr("rtype_or",  6'h00, 6'h25, 1'b0, 32'h0A943210, 7);
    run_instr("rtype_bad", 6'h00, 6'h3F, 1'b0, 32'h00043210, 5);
    run_instr("op_bad",    6'h3F, 6'h20, 1'b1, 32'h00043210, 5);
    run_instr("jump",      6'h02, 6'h00, 1'b0, 32'h00C43210, 6);
`ifdef MIPS_CTRL_ADDI_EN
    run_instr("addi",      6'h08, 6'h00, 1'b0, 32'h0ED43210, 7);
`else
    run_instr("addi_off",  6'h08, 6'h00, 1'b0, 32'h00043210, 5);
`endif
    run_instr("sb",        6'h28, 6'h00, 1'b0, 32'h08543210, 7);

    // Reset asserted in the middle of SBWR takes effect with no clock edge.
    run_instr("sb_pre",    6'h28, 6'h00, 1'b0, 32'h00543210, 6);
    check("sbwr_before_reset", obs, exp_vec(4'd8, 6'h28, 6'h00, 1'b0));
    reset_n = 1'b0; #1;
    check("sbwr_async_reset", obs, exp_reset());
    @(negedge clk); #1;
    check("reset_after_edge", obs, exp_reset());
    reset_n = 1'b1; #1;
    run_instr("lb_after",  6'h20, 6'h00, 1'b0, 32'h76543210, 8);
    check("final_fetch1", obs, exp_vec(4'd0, 6'h20, 6'h00, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
